// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared constants and types for the DSP issue controller.
// Holds the opcode map, ALUOp encodings, sequencer state enum and the
// packed control bundle produced by the opcode decoder.
package dsp_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_DSP   = 6'd1;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // Decoded control bundle for one valid instruction in IDLE.
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       dsp_or_alu;
        logic       dsp_issue;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/dsp_ctrl_decode.sv
// dsp_ctrl_decode: purely combinational opcode-to-control table.
// Ports:
//   opcode  in   6         instruction opcode
//   dsp_idx in   DSPCTL_W  DSP sub-op index (funct slice)
//   ctrl_c  out  ctrl_t    decoded controls; dsp_issue marks a legal DSP op
// RegWrite for DSP ops depends on latency and is resolved by the sequencer.
module dsp_ctrl_decode
    import dsp_ctrl_pkg::*;
#(
    parameter int unsigned DSPCTL_W   = 5,
    parameter int unsigned DSP_OPS    = 4,
    parameter logic [5:0]  DSP_OPCODE = 6'd1
) (
    input  logic [5:0]          opcode,
    input  logic [DSPCTL_W-1:0] dsp_idx,
    output ctrl_t               ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        if (opcode == DSP_OPCODE) begin
            if (32'(dsp_idx) < DSP_OPS) begin
                ctrl_c.dsp_issue  = 1'b1;
                ctrl_c.dsp_or_alu = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
            end else begin
                ctrl_c.illegal = 1'b1;
            end
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl_c.reg_dst   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    ctrl_c.alu_src    = 1'b1;
                    ctrl_c.mem_to_reg = 1'b1;
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.mem_read   = 1'b1;
                    ctrl_c.alu_op     = ALUOP_ADD;
                end
                OP_SW: begin
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.mem_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_ADD;
                end
                OP_BEQ: begin
                    ctrl_c.branch = 1'b1;
                    ctrl_c.alu_op = ALUOP_SUB;
                end
                OP_ADDI: begin
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_ADD;
                end
                default: ctrl_c.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dsp_issue_control.sv
// dsp_issue_control: main decoder plus multi-cycle DSP issue sequencer.
// Standard opcodes decode in one cycle; a legal DSP op launches with
// dsp_start and stalls the front-end (instr_ready=0) until writeback.
// Ports:
//   clk, reset (async, active-high)
//   instr_valid, Opcode[5:0], funct[5:0]          instruction in
//   instr_ready                                   accept / stall
//   RegDst RegWrite ALUSrc MemtoReg MemRead MemWrite Branch ALUOp[1:0]
//   dsporALU, dspcontrol[DSPCTL_W-1:0], dsp_start DSP controls
//   illegal_op                                    unknown opcode / DSP index
// Optional feature macro DSP_ISSUE_PERF_EN adds saturating counters
//   perf_dsp_issues[15:0] and perf_stall_cycles[15:0].
// All outputs are forced to 0 while reset is high.
module dsp_issue_control
    import dsp_ctrl_pkg::*;
#(
    parameter int unsigned DSPCTL_W   = 5,
    parameter int unsigned DSP_OPS    = 4,
    parameter int unsigned DSP_LAT    = 3,
    parameter logic [5:0]  DSP_OPCODE = 6'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [5:0]          Opcode,
    input  logic [5:0]          funct,
    output logic                instr_ready,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic [1:0]          ALUOp,
    output logic                dsporALU,
    output logic [DSPCTL_W-1:0] dspcontrol,
    output logic                dsp_start,
`ifdef DSP_ISSUE_PERF_EN
    output logic [15:0]         perf_dsp_issues,
    output logic [15:0]         perf_stall_cycles,
`endif
    output logic                illegal_op
);

    state_t                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [DSPCTL_W-1:0]    dsp_op_q, dsp_op_d;
    logic [DSPCTL_W-1:0]    dsp_idx;
    ctrl_t                  dec_c;
    logic                   funct_unused;

    assign dsp_idx      = funct[DSPCTL_W-1:0];
    assign funct_unused = ^funct;

    dsp_ctrl_decode #(
        .DSPCTL_W   (DSPCTL_W),
        .DSP_OPS    (DSP_OPS),
        .DSP_OPCODE (DSP_OPCODE)
    ) u_decode (
        .opcode  (Opcode),
        .dsp_idx (dsp_idx),
        .ctrl_c  (dec_c)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= '0;
            dsp_op_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            dsp_op_q  <= dsp_op_q == dsp_op_d ? dsp_op_q : dsp_op_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        dsp_op_d    = dsp_op_q;
        instr_ready = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Branch      = 1'b0;
        ALUOp       = ALUOP_ADD;
        dsporALU    = 1'b0;
        dspcontrol  = '0;
        dsp_start   = 1'b0;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        RegDst     = dec_c.reg_dst;
                        RegWrite   = dec_c.reg_write;
                        ALUSrc     = dec_c.alu_src;
                        MemtoReg   = dec_c.mem_to_reg;
                        MemRead    = dec_c.mem_read;
                        MemWrite   = dec_c.mem_write;
                        Branch     = dec_c.branch;
                        ALUOp      = dec_c.alu_op;
                        dsporALU   = dec_c.dsp_or_alu;
                        illegal_op = dec_c.illegal;
                        if (dec_c.dsp_issue) begin
                            dsp_start  = 1'b1;
                            dspcontrol = dsp_idx;
                            dsp_op_d   = dsp_idx;
                            // Single-cycle DSP writes back in the issue cycle.
                            if (DSP_LAT == 1) begin
                                RegWrite = 1'b1;
                            end else begin
                                lat_cnt_d = LAT_CNT_W'(DSP_LAT - 1);
                                state_d   = S_BUSY;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    RegDst     = 1'b1;
                    dsporALU   = 1'b1;
                    dspcontrol = dsp_op_q;
                    lat_cnt_d  = lat_cnt_q - LAT_CNT_W'(1);
                    if (lat_cnt_q == LAT_CNT_W'(1)) begin
                        RegWrite = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef DSP_ISSUE_PERF_EN
    logic [15:0] perf_issue_q, perf_issue_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    // Saturating event counters.
    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (dsp_start && perf_issue_q != 16'hFFFF)
            perf_issue_d = perf_issue_q + 16'd1;
        if (state_q == S_BUSY && perf_stall_q != 16'hFFFF)
            perf_stall_d = perf_stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_dsp_issues   = perf_issue_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dsp_issue_control.sv
// tb_dsp_issue_control: three instances (DSP_LAT = 3, 1, 4) share one
// input stream. A directed vector table, hand-written corner sequences and
// random stimulus are compared against a cycle-numbered reference model.
module tb_dsp_issue_control;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [5:0] Opcode;
    logic [5:0] funct;

    // {ready, RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch,
    //  ALUOp[1:0], dsporALU, dspcontrol[4:0], dsp_start, illegal_op}
    logic [17:0] act [3];

    int errors;
    int checks;
    int cyc;

    int        lat_of [3] = '{3, 1, 4};
    bit        m_active [3];
    int        m_issue  [3];
    logic [4:0] m_op    [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       rdy, rd, rw, as, m2r, mrd, mw, br, dsp, st, ill;
        logic [1:0] ao;
        logic [4:0] ctl;
`ifdef DSP_ISSUE_PERF_EN
        logic [15:0] pi, ps;
`endif
        dsp_issue_control #(
            .DSPCTL_W   (5),
            .DSP_OPS    (4),
            .DSP_LAT    ((g == 0) ? 3 : (g == 1) ? 1 : 4),
            .DSP_OPCODE (6'd1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .instr_valid (instr_valid),
            .Opcode      (Opcode),
            .funct       (funct),
            .instr_ready (rdy),
            .RegDst      (rd),
            .RegWrite    (rw),
            .ALUSrc      (as),
            .MemtoReg    (m2r),
            .MemRead     (mrd),
            .MemWrite    (mw),
            .Branch      (br),
            .ALUOp       (ao),
            .dsporALU    (dsp),
            .dspcontrol  (ctl),
            .dsp_start   (st),
`ifdef DSP_ISSUE_PERF_EN
            .perf_dsp_issues   (pi),
            .perf_stall_cycles (ps),
`endif
            .illegal_op  (ill)
        );
        assign act[g] = {rdy, rd, rw, as, m2r, mrd, mw, br, ao, dsp, ctl, st, ill};
    end

    function automatic logic [17:0] pk(input logic rdy, input logic rd, input logic rw,
                                       input logic as, input logic m2r, input logic mrd,
                                       input logic mw, input logic br, input logic [1:0] ao,
                                       input logic dsp, input logic [4:0] ctl,
                                       input logic st, input logic ill);
        return {rdy, rd, rw, as, m2r, mrd, mw, br, ao, dsp, ctl, st, ill};
    endfunction

    function automatic logic [17:0] ready_only();
        return pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    endfunction

    function automatic logic [17:0] illegal_v();
        return pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 0, 1);
    endfunction

    function automatic bit model_busy(input int i);
        return m_active[i] && cyc > m_issue[i] && cyc < m_issue[i] + lat_of[i];
    endfunction

    // Expected outputs from the rules: an op issued at cycle T stalls
    // T+1..T+L-1 and writes back at T+L-1.
    function automatic logic [17:0] model_out(input int i);
        int L = lat_of[i];
        if (reset) return '0;
        if (model_busy(i))
            return pk(0, 1, (cyc == m_issue[i] + L - 1), 0, 0, 0, 0, 0, 2'b00, 1, m_op[i], 0, 0);
        if (!instr_valid) return ready_only();
        case (Opcode)
            6'd0:  return pk(1, 1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 5'd0, 0, 0);
            6'd35: return pk(1, 0, 1, 1, 1, 1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
            6'd43: return pk(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0, 5'd0, 0, 0);
            6'd4:  return pk(1, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 5'd0, 0, 0);
            6'd8:  return pk(1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 5'd0, 0, 0);
            6'd1: begin
                if (funct < 6'd4)
                    return pk(1, 1, (L == 1), 0, 0, 0, 0, 0, 2'b00, 1, funct[4:0], 1, 0);
                return illegal_v();
            end
            default: return illegal_v();
        endcase
    endfunction

    task automatic check(input string name, input logic [17:0] a, input logic [17:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    // Drive one cycle, compare all instances to the model, advance the model.
    task automatic step(input logic r, input logic v, input logic [5:0] op, input logic [5:0] fn);
        @(posedge clk);
        #1;
        reset       = r;
        instr_valid = v;
        Opcode      = op;
        funct       = fn;
        #3;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_lat%0d", lat_of[i]), act[i], model_out(i));
        end
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_active[i] = 1'b0;
            end else if (!model_busy(i) && v && op == 6'd1 && fn < 6'd4 && lat_of[i] > 1) begin
                m_active[i] = 1'b1;
                m_issue[i]  = cyc;
                m_op[i]     = fn[4:0];
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic        rst;
        logic        v;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [19];

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        Opcode      = '0;
        funct       = '0;
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0;
            m_issue[i]  = 0;
            m_op[i]     = '0;
        end

        // Expected values for the DSP_LAT=3 instance.
        vecs[0]  = '{1, 1, 6'd35, 6'd0,  '0,                 "rst_lw"};
        vecs[1]  = '{1, 0, 6'd0,  6'd0,  '0,                 "rst_idle"};
        vecs[2]  = '{0, 0, 6'd0,  6'd0,  ready_only(),       "post_rst"};
        vecs[3]  = '{0, 1, 6'd35, 6'd0,  pk(1,0,1,1,1,1,0,0,2'b00,0,5'd0,0,0), "lw"};
        vecs[4]  = '{0, 1, 6'd4,  6'd0,  pk(1,0,0,0,0,0,0,1,2'b01,0,5'd0,0,0), "beq"};
        vecs[5]  = '{0, 1, 6'd7,  6'd0,  illegal_v(),        "op7"};
        vecs[6]  = '{0, 1, 6'd0,  6'd32, pk(1,1,1,0,0,0,0,0,2'b10,0,5'd0,0,0), "rtype"};
        vecs[7]  = '{0, 1, 6'd43, 6'd0,  pk(1,0,0,1,0,0,1,0,2'b00,0,5'd0,0,0), "sw"};
        vecs[8]  = '{0, 1, 6'd8,  6'd0,  pk(1,0,1,1,0,0,0,0,2'b00,0,5'd0,0,0), "addi"};
        vecs[9]  = '{0, 1, 6'd1,  6'd2,  pk(1,1,0,0,0,0,0,0,2'b00,1,5'd2,1,0), "dsp_issue"};
        vecs[10] = '{0, 1, 6'd7,  6'd0,  pk(0,1,0,0,0,0,0,0,2'b00,1,5'd2,0,0), "dsp_t1"};
        vecs[11] = '{0, 1, 6'd35, 6'd0,  pk(0,1,1,0,0,0,0,0,2'b00,1,5'd2,0,0), "dsp_wb"};
        vecs[12] = '{0, 0, 6'd0,  6'd0,  ready_only(),       "dsp_t3"};
        vecs[13] = '{0, 1, 6'd1,  6'd5,  illegal_v(),        "dsp_bad_idx"};
        vecs[14] = '{0, 0, 6'd0,  6'd0,  ready_only(),       "bad_idx_idle"};
        vecs[15] = '{0, 1, 6'd1,  6'd3,  pk(1,1,0,0,0,0,0,0,2'b00,1,5'd3,1,0), "b2b_issue"};
        vecs[16] = '{0, 1, 6'd1,  6'd3,  pk(0,1,0,0,0,0,0,0,2'b00,1,5'd3,0,0), "b2b_t1"};
        vecs[17] = '{0, 1, 6'd1,  6'd3,  pk(0,1,1,0,0,0,0,0,2'b00,1,5'd3,0,0), "b2b_wb"};
        vecs[18] = '{0, 1, 6'd1,  6'd0,  pk(1,1,0,0,0,0,0,0,2'b00,1,5'd0,1,0), "b2b_next"};

        for (int k = 0; k < 19; k++) begin
            step(vecs[k].rst, vecs[k].v, vecs[k].op, vecs[k].fn);
            check(vecs[k].name, act[0], vecs[k].exp);
        end

        // DSP_LAT=1: issue and writeback in one cycle, no stall.
        step(0, 1, 6'd1, 6'd1);
        check("lat1_issue", act[1], pk(1,1,1,0,0,0,0,0,2'b00,1,5'd1,1,0));

        // DSP_LAT=4 op issued above; reset at T+1 abandons it.
        step(1, 0, 6'd0, 6'd0);
        check("lat4_rst_t1", act[2], '0);
        step(1, 1, 6'd8, 6'd0);
        check("lat4_rst_hold", act[2], '0);
        step(0, 1, 6'd8, 6'd0);
        check("lat4_addi", act[2], pk(1,0,1,1,0,0,0,0,2'b00,0,5'd0,0,0));
        check("lat1_ready", act[1], pk(1,0,1,1,0,0,0,0,2'b00,0,5'd0,0,0));
`ifdef DSP_ISSUE_PERF_EN
        check("perf_issues_rst", 18'(g_dut[2].pi), '0);
        check("perf_stall_rst", 18'(g_dut[2].ps), '0);
`endif
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 6'd0, 6'd0);
            check("lat4_no_wb", act[2], ready_only());
        end

        // Random stimulus against the model.
        for (int n = 0; n < 1500; n++) begin
            logic       r, v;
            logic [5:0] op, fn;
            int         sel;
            r   = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = 6'd0;
                1: op = 6'd35;
                2: op = 6'd43;
                3: op = 6'd4;
                4: op = 6'd8;
                8: op = 6'($urandom_range(0, 63));
                9: op = 6'd7;
                default: op = 6'd1;
            endcase
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 31));
            else                           fn = 6'($urandom_range(0, 7));
            step(r, v, op, fn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
